// File: rtl/csa_reduce_stage_pkg.sv
// Shared definitions for the carry-save modular reduction stage:
// control FSM encoding and the width of the quotient estimate.
package csa_reduce_stage_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD1 = 2'd1;
    localparam logic [1:0] ST_LOAD2 = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam int EST_W = 2;

endpackage

// File: rtl/csa_reduce_stage_compress.sv
// N-bit 3:2 carry-save compressor: sum is the bitwise XOR, carry is the
// bitwise majority shifted up one place with the top carry discarded.
module csa_compress #(
    parameter int N = 35
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    logic [N-2:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a[N-2:0] & b[N-2:0]) | (a[N-2:0] & c[N-2:0]) | (b[N-2:0] & c[N-2:0]);
    assign carry = {maj, 1'b0};

endmodule

// File: rtl/csa_reduce_stage.sv
// One reduction step on a carry-save pair: estimate how many 2M multiples to
// remove from the top bits, then fold the matching negative multiple back in.
module csa_reduce_stage
    import csa_reduce_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mod_load,
    input  logic [W-1:0]   mod_in,
    output logic           mod_ready,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W+2:0]   in_s,
    input  logic [W+2:0]   in_c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+2:0]   out_s,
    output logic [W+2:0]   out_c
);

    localparam int CW = W + 3;

    logic [1:0]          state_r;
    logic [1:0]          state_nxt;
    logic                lat_mod;
    logic                calc_m6;
    logic                calc_neg;

    logic [CW-1:0]       m2_r;
    logic [CW-1:0]       m4_r;
    logic [CW-1:0]       m6_r;
    logic [CW-1:0]       neg_tbl [4];

    logic                vld_p1;
    logic                vld_p2;
    logic [CW-1:0]       s_p1;
    logic [CW-1:0]       c_p1;
    logic [CW-1:0]       neg_p1;

    logic                pipe_empty;
    logic                adv1;
    logic                adv2;
    logic                acc;

    logic                b_est;
    logic                lsb_cy;
    logic [EST_W-1:0]    f_est;

    logic [CW-1:0]       cs_sum;
    logic [CW-1:0]       cs_carry;

    assign pipe_empty = !vld_p1 && !vld_p2;
    assign adv2       = !vld_p2 || out_ready;
    assign adv1       = !vld_p1 || adv2;
    assign in_ready   = mod_ready && adv1;
    assign acc        = in_valid && in_ready;
    assign out_valid  = vld_p2;

    // Control FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE:  if (mod_load) state_nxt = ST_LOAD1;
            ST_LOAD1: state_nxt = ST_LOAD2;
            ST_LOAD2: state_nxt = ST_RUN;
            ST_RUN:   if (mod_load && pipe_empty) state_nxt = ST_LOAD1;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mod_ready = 1'b0;
        lat_mod   = 1'b0;
        calc_m6   = 1'b0;
        calc_neg  = 1'b0;
        case (state_r)
            ST_IDLE:  lat_mod = mod_load;
            ST_LOAD1: calc_m6 = 1'b1;
            ST_LOAD2: calc_neg = 1'b1;
            ST_RUN: begin
                mod_ready = 1'b1;
                lat_mod   = mod_load && pipe_empty;
            end
            default: ;
        endcase
    end

    // Multiples table: 2M/4M latched, 6M added in LOAD1, negatives in LOAD2
    always_ff @(posedge clk) begin
        if (rst) begin
            m2_r       <= '0;
            m4_r       <= '0;
            m6_r       <= '0;
            neg_tbl[0] <= '0;
            neg_tbl[1] <= '0;
            neg_tbl[2] <= '0;
            neg_tbl[3] <= '0;
        end else begin
            if (lat_mod) begin
                m2_r <= {2'b00, mod_in, 1'b0};
                m4_r <= {1'b0, mod_in, 2'b00};
            end
            if (calc_m6) begin
                m6_r <= m2_r + m4_r;
            end
            if (calc_neg) begin
                neg_tbl[0] <= '0;
                neg_tbl[1] <= '0 - m2_r;
                neg_tbl[2] <= '0 - m4_r;
                neg_tbl[3] <= '0 - m6_r;
            end
        end
    end

    // Quotient estimate: top three bits of both words plus the carry out of
    // bit W-1 when both words have it set; halved with the LSB carry folded in.
    assign b_est  = in_s[W-1] & in_c[W-1];
    assign lsb_cy = (in_s[W] & in_c[W]) | (in_s[W] & b_est) | (in_c[W] & b_est);
    assign f_est  = in_s[W+2:W+1] + in_c[W+2:W+1] + {1'b0, lsb_cy};

    csa_compress #(
        .N (CW)
    ) u_compress (
        .a     (s_p1),
        .b     (c_p1),
        .c     (neg_p1),
        .sum   (cs_sum),
        .carry (cs_carry)
    );

    // Stage boundary p1 (estimate + table lookup) -> p2 (compressed output)
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            s_p1   <= '0;
            c_p1   <= '0;
            neg_p1 <= '0;
            out_s  <= '0;
            out_c  <= '0;
        end else begin
            if (adv2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    out_s <= cs_sum;
                    out_c <= cs_carry;
                end
            end
            if (adv1) begin
                vld_p1 <= acc;
                if (acc) begin
                    s_p1   <= in_s;
                    c_p1   <= in_c;
                    neg_p1 <= neg_tbl[f_est];
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_reduce_stage.sv
// Randomized bench for csa_reduce_stage at W=8 against an arithmetic model of
// the reduction (in_s + in_c - f*2M mod 2^11) kept in an ordered queue.
module tb_csa_reduce_stage;

    localparam int W  = 8;
    localparam int CW = W + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mod_load = 1'b0;
    logic [W-1:0]  mod_in = '0;
    logic          mod_ready;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_s = '0;
    logic [CW-1:0] in_c = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_s;
    logic [CW-1:0] out_c;

    csa_reduce_stage #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mod_load  (mod_load),
        .mod_in    (mod_in),
        .mod_ready (mod_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c)
    );

    always #5 clk = ~clk;

    int            nerr = 0;
    int            nchk = 0;
    int            nrecv = 0;
    int unsigned   mval = 0;
    logic [CW-1:0] expq[$];
    bit            stall_prev = 0;
    logic [CW-1:0] held_s, held_c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] ref_sum(input logic [CW-1:0] s, input logic [CW-1:0] c,
                                              input int unsigned m);
        int unsigned top, f;
        logic [31:0] t;
        top = ((32'(s) >> 8) & 7) + ((32'(c) >> 8) & 7) + ((32'(s) >> 7) & (32'(c) >> 7) & 1);
        f   = (top >> 1) % 4;
        t   = 32'(s) + 32'(c) - f * 2 * m;
        return t[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] ref_neg(input int unsigned k, input int unsigned m);
        logic [31:0] t;
        t = 32'd0 - k * 2 * m;
        return t[CW-1:0];
    endfunction

    always @(negedge clk) begin
        logic [CW-1:0] osum;
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_s", out_s, held_s);
                check("hold_c", out_c, held_c);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    osum = out_s + out_c;
                    check("sum", osum, expq.pop_front());
                    nrecv++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held_s     = out_s;
            held_c     = out_c;
        end
    end

    task automatic do_reset();
        expq.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_neg_table(input string tag);
        check({tag, "_neg0"}, dut.neg_tbl[0], 0);
        check({tag, "_neg1"}, dut.neg_tbl[1], ref_neg(1, mval));
        check({tag, "_neg2"}, dut.neg_tbl[2], ref_neg(2, mval));
        check({tag, "_neg3"}, dut.neg_tbl[3], ref_neg(3, mval));
    endtask

    task automatic load(input int unsigned m);
        mod_in   = m[W-1:0];
        mod_load = 1'b1;
        mval     = m;
        @(posedge clk); #1;
        mod_load = 1'b0;
        check("rdy_c1", mod_ready, 0);
        @(posedge clk); #1;
        check("rdy_c2", mod_ready, 0);
        @(posedge clk); #1;
        check("rdy_c3", mod_ready, 1);
        check_neg_table("load");
    endtask

    task automatic send(input logic [CW-1:0] s, input logic [CW-1:0] c);
        int t = 0;
        in_s = s;
        in_c = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        else expq.push_back(ref_sum(s, c, mval));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while (expq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", expq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit drop;
        bit done;
        int base;
        logic [CW-1:0] osum;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mod_ready", mod_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_s", out_s, 0);
        check("rst_out_c", out_c, 0);

        load(32'hC8);
        check("neg2_const", dut.neg_tbl[2], 32'h4E0);

        // Directed latency case: f=2
        out_ready = 1'b1;
        in_s = 11'h300;
        in_c = 11'h100;
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1);
        expq.push_back(ref_sum(11'h300, 11'h100, mval));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_cycle1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_cycle2", out_valid, 1);
        osum = out_s + out_c;
        check("sum_f2_const", osum, 32'h0E0);
        drain();

        send(11'h190, 11'h000);
        send(11'h780, 11'h080);
        drain();

        // Eight-pair stream with output stalled for four cycles
        base = nrecv;
        drop = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(CW'($urandom), CW'($urandom));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (!out_ready && !in_ready) drop = 1;
                end
            end
        join
        drain();
        check("stall_in_ready_drop", drop, 1);
        check("stream_count", nrecv - base, 8);

        // Modulus reload attempted while data is in flight
        out_ready = 1'b0;
        send(CW'($urandom), CW'($urandom));
        send(CW'($urandom), CW'($urandom));
        mod_in   = 8'h55;
        mod_load = 1'b1;
        @(posedge clk); #1;
        mod_load = 1'b0;
        @(posedge clk); #1;
        check("ign_mod_ready", mod_ready, 1);
        check_neg_table("ign");
        drain();

        // Reset with two pairs in flight
        out_ready = 1'b0;
        send(CW'($urandom), CW'($urandom));
        send(CW'($urandom), CW'($urandom));
        do_reset();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_mod_ready", mod_ready, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_neg1", dut.neg_tbl[1], 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_s      = 11'h123;
        in_c      = 11'h456;
        repeat (4) @(posedge clk);
        #1;
        check("postrst_in_ready", in_ready, 0);
        check("postrst_out_valid", out_valid, 0);
        in_valid = 1'b0;
        load(32'hC8);
        send(11'h300, 11'h100);
        drain();

        // Randomized rounds with random moduli and random backpressure
        for (int r = 0; r < 3; r++) begin
            load($urandom_range(1, 255));
            done = 0;
            fork
                begin
                    for (int i = 0; i < 60; i++) send(CW'($urandom), CW'($urandom));
                    done = 1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1 out_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            join
            drain();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
